rtc_bus_ctrl: RTL and testbench

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

---
 rtl/rtc_pkg.sv | 78 +++++++
 rtl/rtc_edge_det.sv | 33 +++
 rtl/rtc_bus_ctrl.sv | 150 +++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus controller.
// Holds the FSM state type, the clr_ctrl bit positions, the default phase
// length, and the decode from state to bus strobes.
package rtc_pkg;

  localparam int unsigned T_PHASE_DEF = 4;

  // Bit positions inside clr_ctrl
  localparam int CLR_LISTO   = 0;
  localparam int CLR_ESCRIBE = 1;
  localparam int CLR_LEE     = 2;

  typedef enum logic [2:0] {
    IDLE,
    A_SET,
    A_STB,
    A_HLD,
    D_SET,
    D_STB,
    D_HLD,
    DONE
  } state_t;

  // Active-low strobes plus the pad output enable, kept together so they
  // can be decoded in one place and registered in one place.
  typedef struct packed {
    logic cs_n;
    logic a_d_n;
    logic wr_n;
    logic rd_n;
    logic oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{cs_n: 1'b1, a_d_n: 1'b1, wr_n: 1'b1,
                                      rd_n: 1'b1, oe: 1'b0};

  function automatic logic is_addr_phase(input state_t s);
    return (s == A_SET) || (s == A_STB) || (s == A_HLD);
  endfunction

  function automatic logic is_data_phase(input state_t s);
    return (s == D_SET) || (s == D_STB) || (s == D_HLD);
  endfunction

  // Bus strobe pattern for a given state; is_rd selects read vs write.
  function automatic strobe_t strobe_decode(input state_t s, input logic is_rd);
    strobe_t st;
    st = STROBE_IDLE;
    if (is_addr_phase(s)) begin
      st.cs_n  = 1'b0;
      st.a_d_n = 1'b0;
      st.oe    = 1'b1;
      st.wr_n  = (s != A_STB);
    end else if (is_data_phase(s)) begin
      st.cs_n = 1'b0;
      st.oe   = ~is_rd;
      st.wr_n = ~((s == D_STB) && !is_rd);
      st.rd_n = ~((s == D_STB) && is_rd);
    end
    return st;
  endfunction

  // Successor of each timed phase; DONE follows the last data phase.
  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      A_SET:   n = A_STB;
      A_STB:   n = A_HLD;
      A_HLD:   n = D_SET;
      D_SET:   n = D_STB;
      D_STB:   n = D_HLD;
      D_HLD:   n = DONE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rtc_edge_det.sv
// Registered 0->1 detector for one request level.
// The level is registered before comparison; after reset the detector stays
// disarmed until the level has been seen low, so a request still held high
// across reset cannot start a transaction.
module rtc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic req_q;
  logic prev_q;
  logic armed_q;

  // Two-stage sample of the level plus the arm flag
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; prev_q must see the old req_q, not the new one.
    if (rst) begin
      req_q   <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      req_q  <= level;
      prev_q <= req_q;
      if (!level) armed_q <= 1'b1;
    end
  end

  assign rise = req_q & ~prev_q & armed_q;

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed address/data bus controller.
// Runs one address and one data phase (setup, strobe, hold of T_PHASE cycles
// each) per request edge, then a one-cycle DONE with a clear pulse upstream.
// Optional feature macro: RTC_BUS_ERR_EN adds a sticky err output flagging
// dropped or ignored request edges.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_PHASE = T_PHASE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic       contro_escribe,
  input  logic       contro_lee,
  output logic [2:0] clr_ctrl,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic [7:0] rd_data,
  output logic       busy,
`ifdef RTC_BUS_ERR_EN
  output logic       err,
`endif
  output logic       done
);

  localparam logic [7:0] PHASE_LOAD = 8'(T_PHASE - 1);

  logic       wr_rise;
  logic       rd_rise;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  strobe_t    strobe_d;
  logic [2:0] clr_d;

  rtc_edge_det u_wr_edge (
    .clk   (clk),
    .rst   (rst),
    .level (contro_escribe),
    .rise  (wr_rise)
  );

  rtc_edge_det u_rd_edge (
    .clk   (clk),
    .rst   (rst),
    .level (contro_lee),
    .rise  (rd_rise)
  );

  // Next-state, phase counter and start-of-transaction latching
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (rd_rise || wr_rise) begin
          state_d = A_SET;
          cnt_d   = PHASE_LOAD;
          is_rd_d = rd_rise;        // read wins a same-cycle collision
          addr_d  = dir;
          data_d  = dato;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (cnt_q == 8'd0) begin
          state_d = next_phase(state_q);
          cnt_d   = PHASE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with state
  always_comb begin
    strobe_d = strobe_decode(state_d, is_rd_d);
    clr_d    = '0;
    if (state_d == DONE) begin
      if (is_rd_d) clr_d[CLR_LEE]     = 1'b1;
      else         clr_d[CLR_ESCRIBE] = 1'b1;
    end
  end

  // State, counter, latched transaction and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d_n    <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clr_ctrl <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_rd_q  <= is_rd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cs_n     <= strobe_d.cs_n;
      rd_n     <= strobe_d.rd_n;
      wr_n     <= strobe_d.wr_n;
      a_d_n    <= strobe_d.a_d_n;
      ad_oe    <= strobe_d.oe;
      ad_out   <= is_addr_phase(state_d) ? addr_d :
                  is_data_phase(state_d) ? data_d : 8'h00;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      clr_ctrl <= clr_d;
      if (state_q == D_STB && cnt_q == 8'd0 && is_rd_q) rd_data <= ad_in;
    end
  end

`ifdef RTC_BUS_ERR_EN
  // Sticky flag: write dropped by a same-cycle read, or any edge while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state_q == IDLE && rd_rise && wr_rise) ||
                 (state_q != IDLE && (rd_rise || wr_rise))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed testbench for rtc_bus_ctrl.
// Expected bus waveforms are built cycle by cycle from the phase timing
// (cycle j counted from the clock edge that first samples the request high).
module tb_rtc_bus_ctrl;

  localparam int TP     = 4;
  localparam int DONE_J = 6 * TP + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dir, dato, ad_in;
  logic       contro_escribe, contro_lee;
  logic [2:0] clr_ctrl;
  logic       cs_n, rd_n, wr_n, a_d_n, ad_oe, busy, done;
  logic [7:0] ad_out, rd_data;
`ifdef RTC_BUS_ERR_EN
  logic       err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [17:0] act;
  assign act = {cs_n, a_d_n, wr_n, rd_n, ad_oe, done, busy, ad_out, clr_ctrl};

  always #5 clk = ~clk;

  rtc_bus_ctrl #(.T_PHASE(TP)) dut (
    .clk            (clk),
    .rst            (rst),
    .dir            (dir),
    .dato           (dato),
    .contro_escribe (contro_escribe),
    .contro_lee     (contro_lee),
    .clr_ctrl       (clr_ctrl),
    .cs_n           (cs_n),
    .rd_n           (rd_n),
    .wr_n           (wr_n),
    .a_d_n          (a_d_n),
    .ad_out         (ad_out),
    .ad_oe          (ad_oe),
    .ad_in          (ad_in),
    .rd_data        (rd_data),
    .busy           (busy),
`ifdef RTC_BUS_ERR_EN
    .err            (err),
`endif
    .done           (done)
  );

  // Expected {cs_n,a_d_n,wr_n,rd_n,ad_oe,done,busy,ad_out,clr_ctrl} at cycle j
  function automatic logic [17:0] exp_vec(input int j, input bit rd,
                                          input logic [7:0] a, input logic [7:0] d);
    logic cs_e, ad_e, wr_e, rd_e, oe_e, dn_e, bs_e;
    logic [7:0] out_e;
    logic [2:0] clr_e;
    int p;
    cs_e = 1'b1; ad_e = 1'b1; wr_e = 1'b1; rd_e = 1'b1;
    oe_e = 1'b0; dn_e = 1'b0; bs_e = 1'b0; out_e = 8'h00; clr_e = 3'b000;
    if (j >= 1 && j <= 6 * TP) begin
      p     = (j - 1) / TP;
      cs_e  = 1'b0;
      ad_e  = (p >= 3);
      wr_e  = !(p == 1 || (p == 4 && !rd));
      rd_e  = !(p == 4 && rd);
      oe_e  = (p < 3) || !rd;
      bs_e  = 1'b1;
      out_e = (p < 3) ? a : d;
    end else if (j == DONE_J) begin
      dn_e  = 1'b1;
      bs_e  = 1'b1;
      clr_e = rd ? 3'b100 : 3'b010;
    end
    return {cs_e, ad_e, wr_e, rd_e, oe_e, dn_e, bs_e, out_e, clr_e};
  endfunction

  task automatic test_reset();
    logic [17:0] e;
    rst = 1'b1;
    contro_escribe = 1'b0; contro_lee = 1'b0;
    dir = 8'hA5; dato = 8'h5A; ad_in = 8'hFF;
    repeat (3) @(negedge clk);
    e = exp_vec(0, 1'b0, 8'h00, 8'h00);
    total_cnt++;
    if (act !== e) $display("FAIL reset_outputs: got %h expected %h", act, e);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    else pass_cnt++;
`ifdef RTC_BUS_ERR_EN
    total_cnt++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
    else pass_cnt++;
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_write();
    logic [17:0] e;
    dir = 8'h21; dato = 8'h5A;
    contro_escribe = 1'b1;
    for (int j = 0; j <= DONE_J + 3; j++) begin
      @(negedge clk);
      e = exp_vec(j, 1'b0, 8'h21, 8'h5A);
      total_cnt++;
      if (act !== e) $display("FAIL write j=%0d: got %h expected %h", j, act, e);
      else pass_cnt++;
      if (j == 3) begin
        dir = 8'hFF; dato = 8'h00;   // must not disturb the latched values
      end
    end
    total_cnt++;
    if (rd_data !== 8'h00) $display("FAIL write_rd_data: got %h expected 00", rd_data);
    else pass_cnt++;
    contro_escribe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    logic [17:0] e;
    dir = 8'h22; dato = 8'h99; ad_in = 8'hFF;
    contro_lee = 1'b1;
    for (int j = 0; j <= DONE_J + 3; j++) begin
      @(negedge clk);
      e = exp_vec(j, 1'b1, 8'h22, 8'h99);
      total_cnt++;
      if (act !== e) $display("FAIL read j=%0d: got %h expected %h", j, act, e);
      else pass_cnt++;
      if (j == 20) ad_in = 8'hC3;    // present only for the last D_STB cycle
      if (j == 21) ad_in = 8'h3C;
    end
    total_cnt++;
    if (rd_data !== 8'hC3) $display("FAIL read_rd_data: got %h expected c3", rd_data);
    else pass_cnt++;
    contro_lee = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [17:0] e;
    dir = 8'h33; dato = 8'h77; ad_in = 8'h9E;
    contro_escribe = 1'b1; contro_lee = 1'b1;
    for (int j = 0; j <= DONE_J + 3; j++) begin
      @(negedge clk);
      e = exp_vec(j, 1'b1, 8'h33, 8'h77);
      total_cnt++;
      if (act !== e) $display("FAIL simultaneous j=%0d: got %h expected %h", j, act, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (rd_data !== 8'h9E) $display("FAIL simultaneous_rd_data: got %h expected 9e", rd_data);
    else pass_cnt++;
`ifdef RTC_BUS_ERR_EN
    total_cnt++;
    if (err !== 1'b1) $display("FAIL simultaneous_err: got %b expected 1", err);
    else pass_cnt++;
`endif
    contro_escribe = 1'b0; contro_lee = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy();
    logic [17:0] e;
    int busy_cnt = 0;
    int done_cnt = 0;
    dir = 8'h44; dato = 8'hAB; ad_in = 8'h5D;
    contro_lee = 1'b1;
    for (int j = 0; j <= DONE_J + 6; j++) begin
      @(negedge clk);
      e = exp_vec(j, 1'b1, 8'h44, 8'hAB);
      total_cnt++;
      if (act !== e) $display("FAIL busy_ignore j=%0d: got %h expected %h", j, act, e);
      else pass_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (j == 8) contro_escribe = 1'b1;   // edge during A_STB of the read
    end
    total_cnt++;
    if (done_cnt != 1) $display("FAIL busy_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (busy_cnt != DONE_J) $display("FAIL busy_length: got %0d expected %0d", busy_cnt, DONE_J);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'h5D) $display("FAIL busy_rd_data: got %h expected 5d", rd_data);
    else pass_cnt++;
    contro_escribe = 1'b0; contro_lee = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    int bad_cnt = 0;
    dir = 8'h55; dato = 8'hC6;
    contro_escribe = 1'b1;
    for (int j = 0; j <= 18; j++) begin
      @(negedge clk);
      e = exp_vec(j, 1'b0, 8'h55, 8'hC6);
      total_cnt++;
      if (act !== e) $display("FAIL reset_mid_pre j=%0d: got %h expected %h", j, act, e);
      else pass_cnt++;
    end
    rst = 1'b1;                        // FSM is in D_STB here
    @(negedge clk);
    e = exp_vec(0, 1'b0, 8'h00, 8'h00);
    total_cnt++;
    if (act !== e) $display("FAIL reset_mid_abort: got %h expected %h", act, e);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'h00) $display("FAIL reset_mid_rd_data: got %h expected 00", rd_data);
    else pass_cnt++;
`ifdef RTC_BUS_ERR_EN
    total_cnt++;
    if (err !== 1'b0) $display("FAIL reset_mid_err: got %b expected 0", err);
    else pass_cnt++;
`endif
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || clr_ctrl !== 3'b000) bad_cnt++;
    end
    total_cnt++;
    if (bad_cnt != 0) $display("FAIL reset_mid_held_level: got %0d active cycles expected 0", bad_cnt);
    else pass_cnt++;
    contro_escribe = 1'b0;
    @(negedge clk);
    contro_escribe = 1'b1;
    for (int j = 0; j <= DONE_J + 2; j++) begin
      @(negedge clk);
      e = exp_vec(j, 1'b0, 8'h55, 8'hC6);
      total_cnt++;
      if (act !== e) $display("FAIL reset_mid_rearm j=%0d: got %h expected %h", j, act, e);
      else pass_cnt++;
    end
    contro_escribe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_level();
    int done_cnt = 0;
    int first_j  = -1;
    dir = 8'h66; dato = 8'h12;
    contro_escribe = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (first_j < 0) first_j = j;
      end
    end
    total_cnt++;
    if (done_cnt != 1) $display("FAIL level_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (first_j != DONE_J) $display("FAIL level_done_latency: got %0d expected %0d", first_j, DONE_J);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL level_idle_after: got %b expected 0", busy);
    else pass_cnt++;
    contro_escribe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_busy();
    test_reset_mid();
    test_level();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
